// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// A request is captured in IDLE, executed in EXEC and returned in RESP.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_function,
  input  logic        req0_word,
  input  logic [63:0] req0_operand_a,
  input  logic [63:0] req0_operand_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_function,
  input  logic        req1_word,
  input  logic [63:0] req1_operand_a,
  input  logic [63:0] req1_operand_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_result,

  output logic [3:0]  alu_function,
  output logic        alu_word,
  output logic [63:0] alu_operand_a,
  output logic [63:0] alu_operand_b,
  input  logic [63:0] alu_result
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned FUNC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              word;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_op_t;

  state_t              state;
  alu_op_t             op_q;
  logic                owner_q;
  logic [DATA_W-1:0]   result_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic                last_grant_q;
`endif

  alu_op_t             req0_op_c;
  alu_op_t             req1_op_c;
  logic                grant0_c;
  logic                grant1_c;
  logic                owner_rsp_ready_c;

  assign req0_op_c = {req0_function, req0_word, req0_operand_a, req0_operand_b};
  assign req1_op_c = {req1_function, req1_word, req1_operand_a, req1_operand_b};

  // Arbitration: grants only in IDLE and never while reset is asserted.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (rst_n && (state == IDLE)) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        grant0_c = last_grant_q;
        grant1_c = !last_grant_q;
      end else begin
        grant0_c = req0_valid;
        grant1_c = req1_valid;
      end
`else
      grant0_c = req0_valid;
      grant1_c = req1_valid && !req0_valid;
`endif
    end
  end

  assign req0_ready        = grant0_c;
  assign req1_ready        = grant1_c;
  assign owner_rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;

  // FSM with captured operation, owner, result and response valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      owner_q      <= 1'b0;
      result_q     <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c || grant1_c) begin
            op_q    <= grant1_c ? req1_op_c : req0_op_c;
            owner_q <= grant1_c;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant_q <= grant1_c;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          result_q   <= alu_result;
          rsp0_valid <= !owner_q;
          rsp1_valid <= owner_q;
          state      <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready_c) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Shared ALU sees the captured operation, held between operations.
  assign alu_function  = op_q.func;
  assign alu_word      = op_q.word;
  assign alu_operand_a = op_q.a;
  assign alu_operand_b = op_q.b;
  assign rsp_result    = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed stimulus, scoreboard queue plus a monitor
// that checks every response handshake. Also models the external shared ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_word;
  logic [3:0]  req0_function;
  logic [63:0] req0_operand_a, req0_operand_b;
  logic        req1_valid, req1_ready, req1_word;
  logic [3:0]  req1_function;
  logic [63:0] req1_operand_a, req1_operand_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp_result;
  logic [3:0]  alu_function;
  logic        alu_word;
  logic [63:0] alu_operand_a, alu_operand_b, alu_result;

  typedef struct {
    logic        port;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic win_exp [4];

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_function(req0_function),
    .req0_word(req0_word), .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_function(req1_function),
    .req1_word(req1_word), .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_function(alu_function), .alu_word(alu_word),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the external RV64 integer ALU.
  function automatic logic [63:0] alu_model(input logic [3:0] f, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] r32;
    logic [5:0]  sh;
    sh  = w ? {1'b0, b[4:0]} : b[5:0];
    r   = '0;
    r32 = '0;
    case (f[2:0])
      3'd0: r = f[3] ? (a - b) : (a + b);
      3'd1: r = a << sh;
      3'd2: r = {63'd0, ($signed(a) < $signed(b))};
      3'd3: r = {63'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: begin
        if (w) begin
          if (f[3]) r32 = $signed(a[31:0]) >>> sh;
          else      r32 = a[31:0] >> sh;
          r = {32'd0, r32};
        end else begin
          if (f[3]) r = $signed(a) >>> sh;
          else      r = a >> sh;
        end
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  assign alu_result = alu_model(alu_function, alu_word, alu_operand_a, alu_operand_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops and checks one expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp1_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_both_valid: got 1 expected 0 at %0t", $time);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got result %h with empty scoreboard at %0t",
                   rsp_result, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check1("rsp_port", rsp1_valid, mon_e.port);
          check("rsp_result", rsp_result, mon_e.data);
        end
      end
    end
  end

  // Present one request, wait (bounded) for its grant, then drop valid after the accept edge.
  task automatic issue(input logic port, input logic [3:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int   n;
    logic ok;
    exp_t e;
    n = 0;
    if (!port) begin
      req0_valid = 1'b1; req0_function = f; req0_word = w;
      req0_operand_a = a; req0_operand_b = b;
    end else begin
      req1_valid = 1'b1; req1_function = f; req1_word = w;
      req1_operand_a = a; req1_operand_b = b;
    end
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    ok = port ? req1_ready : req0_ready;
    check1("issue_accept", ok, 1'b1);
    if (ok) begin
      e.port = port;
      e.data = exp;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
  endtask

  // Wait (bounded) until all expected responses are consumed, end just after an edge.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("drain", sb_q.size() == 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    win_exp[0] = 1'b0; win_exp[1] = 1'b1; win_exp[2] = 1'b0; win_exp[3] = 1'b1;
`else
    win_exp[0] = 1'b0; win_exp[1] = 1'b0; win_exp[2] = 1'b0; win_exp[3] = 1'b0;
`endif
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_function = 4'b0000; req0_word = 1'b0;
    req0_operand_a = 64'd5; req0_operand_b = 64'd3;
    req1_valid = 1'b0; req1_function = 4'b0000; req1_word = 1'b0;
    req1_operand_a = '0; req1_operand_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, with a request already pending.
    #12;
    check1("rst_req0_ready", req0_ready, 1'b0);
    check1("rst_rsp0_valid", rsp0_valid, 1'b0);
    check1("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_alu_a", alu_operand_a, 64'd0);
    check("rst_alu_fn", {60'd0, alu_function}, 64'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ADD on port 0 with latency checks.
    issue(1'b0, 4'b0000, 1'b0, 64'd5, 64'd3, 64'd8);
    @(negedge clk);
    check1("lat_exec_rsp0_valid", rsp0_valid, 1'b0);
    check("exec_alu_a", alu_operand_a, 64'd5);
    check("exec_alu_b", alu_operand_b, 64'd3);
    @(negedge clk);
    check1("lat_resp_rsp0_valid", rsp0_valid, 1'b1);
    check1("lat_resp_rsp1_valid", rsp1_valid, 1'b0);
    drain();

    // Operand change after accept must not affect the result.
    issue(1'b0, 4'b0000, 1'b0, 64'd5, 64'd3, 64'd8);
    req0_operand_a = 64'd99;
    drain();

    // Word SUB on port 1: 0 - 1 sign-extended.
    issue(1'b1, 4'b1000, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();

    // Backpressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    req1_valid = 1'b1; req1_function = 4'b0001; req1_word = 1'b0;
    req1_operand_a = 64'd1; req1_operand_b = 64'd4;
    issue(1'b0, 4'b0100, 1'b0, 64'hF0, 64'hFF, 64'h0F);
    @(negedge clk);
    check1("bp_exec_req1_ready", req1_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("bp_rsp0_valid", rsp0_valid, 1'b1);
      check("bp_rsp_result", rsp_result, 64'h0F);
      check1("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check1("bp_release_rsp0_valid", rsp0_valid, 1'b0);
    check1("bp_release_req1_ready", req1_ready, 1'b1);
    if (req1_ready) begin
      e.port = 1'b1;
      e.data = 64'd16;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain();

    // Contention: both requesters hold valid for four operations.
    req0_valid = 1'b1; req0_function = 4'b0000; req0_word = 1'b0;
    req0_operand_a = 64'd10; req0_operand_b = 64'd1;
    req1_valid = 1'b1; req1_function = 4'b1101; req1_word = 1'b0;
    req1_operand_a = 64'h8000_0000_0000_0000; req1_operand_b = 64'd4;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 50) begin
        n++;
        @(negedge clk);
      end
      check1("cont_grant", req0_ready || req1_ready, 1'b1);
      check1("cont_both_ready", req0_ready && req1_ready, 1'b0);
      check1("cont_winner", req1_ready, win_exp[i]);
      if (req0_ready || req1_ready) begin
        e.port = req1_ready;
        e.data = req1_ready ? 64'hF800_0000_0000_0000 : 64'd11;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    drain();

    // Asynchronous reset during EXEC discards the operation.
    issue(1'b0, 4'b0000, 1'b0, 64'd7, 64'd7, 64'd14);
    req0_valid = 1'b1; req0_function = 4'b1000; req0_word = 1'b0;
    req0_operand_a = 64'd10; req0_operand_b = 64'd3;
    #3;
    rst_n = 1'b0;
    #1;
    check1("arst_rsp0_valid", rsp0_valid, 1'b0);
    check1("arst_req0_ready", req0_ready, 1'b0);
    check("arst_rsp_result", rsp_result, 64'd0);
    check("arst_alu_a", alu_operand_a, 64'd0);
    sb_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check1("arst_hold_rsp0_valid", rsp0_valid, 1'b0);
      check1("arst_hold_req0_ready", req0_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_req0_ready", req0_ready, 1'b1);
    if (req0_ready) begin
      e.port = 1'b0;
      e.data = 64'd7;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("post_rst_capture_a", alu_operand_a, 64'd10);
    req0_valid = 1'b0;
    drain();

    check1("sb_empty", sb_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-004 SHALL have ports reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-005 SHALL have ports reqN_function  input  4  ALU function code; bit 3 selects SUB/SRA, bits 2:0 select the funct3 group.
REQ-006 SHALL have ports reqN_word  input  1  1 = 32-bit word operation, sign-extended to 64 bits; 0 = 64-bit operation.
REQ-007 SHALL have ports reqN_operand_a and reqN_operand_b  input  64  operands.
REQ-008 SHALL have ports rspN_valid  output  1  result for requester N is available.
REQ-009 SHALL have ports rspN_ready  input  1  requester N consumes the result.
REQ-010 SHALL have port rsp_result  output  64  result shared by both responders; valid only with rspN_valid.
REQ-011 SHALL have ports alu_function  output  4, alu_word  output  1, alu_operand_a and alu_operand_b  output  64  drive the shared ALU.
REQ-012 SHALL have port alu_result  input  64  combinational result from the shared ALU.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-014 IDLE: SHALL assert at most one reqN_ready, combinationally, for the winning requester with reqN_valid=1; on that edge SHALL capture function, word and operands into internal registers, record the owner, and go to EXEC.
REQ-015 IDLE with no reqN_valid SHALL stay in IDLE with both reqN_ready=0.
REQ-016 EXEC: SHALL drive the alu_* outputs from the captured registers and latch alu_result into the result register at the edge, then go to RESP.
REQ-017 RESP: SHALL hold rspN_valid=1 for the owner only, with rsp_result stable.
REQ-018 RESP: SHALL stay in RESP while the owner's rspN_ready=0, and SHALL return to IDLE on the edge where it is 1.
REQ-019 RESP: SHALL NOT accept a new request in the same cycle as the rsp handshake; throughput is one operation per 3 cycles minimum.
REQ-020 Latency: SHALL make rspN_valid rise 2 cycles after the accept edge (accept edge T, first valid cycle T+2).
REQ-021 Outside EXEC, SHALL hold the alu_* outputs at their last captured values; no glitch-free requirement.
REQ-022 Both reqN_ready SHALL be 0 in EXEC and RESP, and rspN_valid SHALL be 0 in IDLE and EXEC.
REQ-023 A simultaneous request on both ports SHALL be resolved by the arbitration policy (REQ-029/030); the loser's request and operands SHALL NOT be captured and SHALL be served later.
REQ-024 Captured values SHALL be unaffected by changes on the req* inputs after acceptance.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear all reqN_ready and rspN_valid, independent of clk.
REQ-026 Reset SHALL clear the captured function, word and operand registers, rsp_result, and the alu_* outputs to 0, and set last_grant=1.
REQ-027 Reset asserted mid-operation (EXEC or RESP) SHALL discard the pending result with no rspN_valid pulse.
REQ-028 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-029 With macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the requester not equal to last_grant, and last_grant SHALL update on each accept.
REQ-030 Without ALU_ARB_ROUND_ROBIN_EN: SHALL apply fixed priority with requester 0 always winning; last_grant may be omitted.

Verification
REQ-031 Single request: req0 ADD (function 0000, word 0), a=5, b=3 -> req0_ready=1 at T, rsp0_valid at T+2, rsp_result=8.
REQ-032 Word SUB: req1 function 1000, word 1, a=0, b=1 -> rsp1_valid with rsp_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-033 Contention with both requesters holding valid for 4 operations -> RR build grants 0,1,0,1; fixed build grants 0,0,0,0 and req1 is never ready.
REQ-034 Backpressure: rsp0_ready=0 for 5 cycles -> FSM stays in RESP, rsp_result stable, req1_ready=0 throughout; release -> IDLE next edge.
REQ-035 Reset in EXEC: rst_n low asynchronously mid-cycle -> outputs cleared immediately, no rsp pulse; after release req0 is accepted on the first edge.
REQ-036 Operand change after accept: a changed from 5 to 99 at T+1 -> result still reflects a=5.
